// File: rtl/pp_pipeline_accel_fifo_srl_prog.sv
// Parametrised shift-register FIFO for pp_pipeline_accel dataflow channels.
// Show-ahead read port, registered status flags, programmable almost-full /
// almost-empty thresholds, synchronous flush, sticky error flags and a
// peak-occupancy watermark.
module pp_pipeline_accel_fifo_srl_prog #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
  parameter int unsigned AF_LEVEL   = DEPTH - 2,
  parameter int unsigned AE_LEVEL   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_flush,
  input  logic                  if_write,
  input  logic                  if_write_ce,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_read,
  input  logic                  if_read_ce,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic [ADDR_WIDTH:0]   if_num_data_valid,
  output logic [ADDR_WIDTH:0]   if_fifo_cap,
  output logic                  if_almost_full,
  output logic                  if_almost_empty,
  output logic                  if_overflow,
  output logic                  if_underflow,
  output logic [ADDR_WIDTH:0]   if_max_level
);

  localparam int unsigned CntW = ADDR_WIDTH + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);
  localparam logic [CntW-1:0] AfC    = CntW'(AF_LEVEL);
  localparam logic [CntW-1:0] AeC    = CntW'(AE_LEVEL);
  localparam logic [CntW-1:0] OneC   = CntW'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [CntW-1:0] count_q, count_d;
  logic [CntW-1:0] max_q, max_d;
  logic            empty_n_q, empty_n_d;
  logic            full_n_q, full_n_d;
  logic            af_q, af_d;
  logic            ae_q, ae_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;

  logic            wr_req, rd_req;
  logic            wr_en, rd_en;
  logic [CntW-1:0]       head_cnt;
  logic [ADDR_WIDTH-1:0] rd_addr;

  assign wr_req = if_write & if_write_ce;
  assign rd_req = if_read & if_read_ce;
  // Flush swallows both requests so nothing shifts in the flush cycle.
  assign wr_en  = wr_req & full_n_q & ~if_flush;
  assign rd_en  = rd_req & empty_n_q & ~if_flush;

  // Next occupancy, flags, error bits and watermark.
  always_comb begin
    count_d = count_q;
    if (if_flush) begin
      count_d = '0;
    end else begin
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + OneC;
        2'b01:   count_d = count_q - OneC;
        default: count_d = count_q;
      endcase
    end

    empty_n_d = (count_d != '0);
    full_n_d  = (count_d != DepthC);
    af_d      = (count_d >= AfC);
    ae_d      = (count_d <= AeC);

    if (if_flush) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
      max_d = '0;
    end else begin
      ovf_d = ovf_q | (wr_req & ~full_n_q);
      unf_d = unf_q | (rd_req & ~empty_n_q);
      max_d = (count_d > max_q) ? count_d : max_q;
    end
  end

  // Status and occupancy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      max_q     <= '0;
      empty_n_q <= 1'b0;
      full_n_q  <= 1'b1;
      af_q      <= 1'b0;
      ae_q      <= 1'b1;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      count_q   <= count_d;
      max_q     <= max_d;
      empty_n_q <= empty_n_d;
      full_n_q  <= full_n_d;
      af_q      <= af_d;
      ae_q      <= ae_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  // Data shift chain; left unreset since occupancy gates what is visible.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[0] <= if_din;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        mem_q[i] <= mem_q[i-1];
      end
    end
  end

  // Head sits at entry count-1; an empty or impossible count falls back to entry 0.
  always_comb begin
    head_cnt = count_q - OneC;
    rd_addr  = '0;
    if ((count_q != '0) && (count_q <= DepthC)) begin
      rd_addr = head_cnt[ADDR_WIDTH-1:0];
    end
  end

  assign if_dout           = mem_q[rd_addr];
  assign if_full_n         = full_n_q;
  assign if_empty_n        = empty_n_q;
  assign if_num_data_valid = count_q;
  assign if_fifo_cap       = DepthC;
  assign if_almost_full    = af_q;
  assign if_almost_empty   = ae_q;
  assign if_overflow       = ovf_q;
  assign if_underflow      = unf_q;
  assign if_max_level      = max_q;

endmodule

// File: tb/tb_pp_pipeline_accel_fifo_srl_prog.sv
// Self-checking bench: default 16x32 instance driven by hand sequences,
// 5-deep instance driven from a vector table plus a mid-fill reset.
module tb_pp_pipeline_accel_fifo_srl_prog;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Default instance (DEPTH 16, AF 14, AE 1)
  logic        b_reset, b_flush, b_write, b_write_ce, b_read, b_read_ce;
  logic [31:0] b_din, b_dout;
  logic        b_full_n, b_empty_n, b_af, b_ae, b_ovf, b_unf;
  logic [4:0]  b_cnt, b_cap, b_max;

  pp_pipeline_accel_fifo_srl_prog u_big (
    .clk               (clk),
    .reset             (b_reset),
    .if_flush          (b_flush),
    .if_write          (b_write),
    .if_write_ce       (b_write_ce),
    .if_din            (b_din),
    .if_full_n         (b_full_n),
    .if_read           (b_read),
    .if_read_ce        (b_read_ce),
    .if_dout           (b_dout),
    .if_empty_n        (b_empty_n),
    .if_num_data_valid (b_cnt),
    .if_fifo_cap       (b_cap),
    .if_almost_full    (b_af),
    .if_almost_empty   (b_ae),
    .if_overflow       (b_ovf),
    .if_underflow      (b_unf),
    .if_max_level      (b_max)
  );

  // Small non-power-of-2 instance (DEPTH 5, AF 4, AE 2)
  logic       s_reset, s_flush, s_write, s_read;
  logic [7:0] s_din, s_dout;
  logic       s_full_n, s_empty_n, s_af, s_ae, s_ovf, s_unf;
  logic [3:0] s_cnt, s_cap, s_max;

  pp_pipeline_accel_fifo_srl_prog #(
    .DATA_WIDTH (8),
    .DEPTH      (5),
    .AF_LEVEL   (4),
    .AE_LEVEL   (2)
  ) u_small (
    .clk               (clk),
    .reset             (s_reset),
    .if_flush          (s_flush),
    .if_write          (s_write),
    .if_write_ce       (1'b1),
    .if_din            (s_din),
    .if_full_n         (s_full_n),
    .if_read           (s_read),
    .if_read_ce        (1'b1),
    .if_dout           (s_dout),
    .if_empty_n        (s_empty_n),
    .if_num_data_valid (s_cnt),
    .if_fifo_cap       (s_cap),
    .if_almost_full    (s_af),
    .if_almost_empty   (s_ae),
    .if_overflow       (s_ovf),
    .if_underflow      (s_unf),
    .if_max_level      (s_max)
  );

  typedef struct {
    logic       wr;
    logic       rd;
    logic [7:0] din;
    int         cnt;
    logic       en;
    logic       fn;
    logic       af;
    logic       ae;
    int         mx;
    logic       dv;
    logic [7:0] dout;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle on the big instance; outputs sampled 1 time unit after the edge.
  task automatic bcyc(input logic fl, input logic w, input logic r, input logic [31:0] d);
    b_flush = fl; b_write = w; b_read = r; b_din = d;
    @(posedge clk); #1;
    b_flush = 1'b0; b_write = 1'b0; b_read = 1'b0;
  endtask

  task automatic scyc(input logic w, input logic r, input logic [7:0] d);
    s_write = w; s_read = r; s_din = d;
    @(posedge clk); #1;
    s_write = 1'b0; s_read = 1'b0;
  endtask

  task automatic chk_big_reset_state(input string tag);
    chk({tag, " count"},   32'(b_cnt),     32'd0);
    chk({tag, " empty_n"}, 32'(b_empty_n), 32'd0);
    chk({tag, " full_n"},  32'(b_full_n),  32'd1);
    chk({tag, " ae"},      32'(b_ae),      32'd1);
    chk({tag, " af"},      32'(b_af),      32'd0);
    chk({tag, " ovf"},     32'(b_ovf),     32'd0);
    chk({tag, " unf"},     32'(b_unf),     32'd0);
    chk({tag, " max"},     32'(b_max),     32'd0);
  endtask

  initial begin
    b_reset = 1'b1; b_flush = 1'b0; b_write = 1'b0; b_write_ce = 1'b1;
    b_read = 1'b0; b_read_ce = 1'b1; b_din = '0;
    s_reset = 1'b1; s_flush = 1'b0; s_write = 1'b0; s_read = 1'b0; s_din = '0;

    // wr rd din | cnt en fn af ae max | dout-valid dout
    vt[0] = '{1, 0, 8'd1, 1, 1, 1, 0, 1, 1, 1, 8'd1};
    vt[1] = '{1, 0, 8'd2, 2, 1, 1, 0, 1, 2, 1, 8'd1};
    vt[2] = '{1, 0, 8'd3, 3, 1, 1, 0, 0, 3, 1, 8'd1};
    vt[3] = '{1, 0, 8'd4, 4, 1, 1, 1, 0, 4, 1, 8'd1};
    vt[4] = '{1, 0, 8'd5, 5, 1, 0, 1, 0, 5, 1, 8'd1};
    vt[5] = '{0, 1, 8'd0, 4, 1, 1, 1, 0, 5, 1, 8'd2};
    vt[6] = '{0, 1, 8'd0, 3, 1, 1, 0, 0, 5, 1, 8'd3};
    vt[7] = '{0, 1, 8'd0, 2, 1, 1, 0, 1, 5, 1, 8'd4};
    vt[8] = '{0, 1, 8'd0, 1, 1, 1, 0, 1, 5, 1, 8'd5};
    vt[9] = '{0, 1, 8'd0, 0, 0, 1, 0, 1, 5, 0, 8'd0};

    repeat (2) @(posedge clk);
    #1;
    b_reset = 1'b0; s_reset = 1'b0;

    // Reset state and constant capacity
    chk_big_reset_state("big reset");
    chk("big cap", 32'(b_cap), 32'd16);
    chk("small cap", 32'(s_cap), 32'd5);

    // Small instance: table-driven fill/drain through both thresholds
    for (int i = 0; i < 10; i++) begin
      scyc(vt[i].wr, vt[i].rd, vt[i].din);
      chk($sformatf("small v%0d count", i),   32'(s_cnt),     32'(vt[i].cnt));
      chk($sformatf("small v%0d empty_n", i), 32'(s_empty_n), 32'(vt[i].en));
      chk($sformatf("small v%0d full_n", i),  32'(s_full_n),  32'(vt[i].fn));
      chk($sformatf("small v%0d af", i),      32'(s_af),      32'(vt[i].af));
      chk($sformatf("small v%0d ae", i),      32'(s_ae),      32'(vt[i].ae));
      chk($sformatf("small v%0d max", i),     32'(s_max),     32'(vt[i].mx));
      if (vt[i].dv) chk($sformatf("small v%0d dout", i), 32'(s_dout), 32'(vt[i].dout));
    end

    // Small: underflow on empty, partial fill, then reset mid-operation
    scyc(1'b0, 1'b1, 8'd0);
    chk("small unf set", 32'(s_unf), 32'd1);
    for (int i = 0; i < 3; i++) scyc(1'b1, 1'b0, 8'(8'h10 + i));
    chk("small refill count", 32'(s_cnt), 32'd3);
    s_reset = 1'b1; s_flush = 1'b1;
    scyc(1'b1, 1'b1, 8'hEE);
    s_reset = 1'b0; s_flush = 1'b0;
    chk("small rst count",   32'(s_cnt),     32'd0);
    chk("small rst empty_n", 32'(s_empty_n), 32'd0);
    chk("small rst full_n",  32'(s_full_n),  32'd1);
    chk("small rst ae",      32'(s_ae),      32'd1);
    chk("small rst af",      32'(s_af),      32'd0);
    chk("small rst ovf",     32'(s_ovf),     32'd0);
    chk("small rst unf",     32'(s_unf),     32'd0);
    chk("small rst max",     32'(s_max),     32'd0);

    // Big: write-enable gating
    b_write_ce = 1'b0;
    bcyc(1'b0, 1'b1, 1'b0, 32'h99);
    b_write_ce = 1'b1;
    chk("big write_ce gated", 32'(b_cnt), 32'd0);

    // Big: fill 0..15
    for (int i = 0; i < 16; i++) begin
      bcyc(1'b0, 1'b1, 1'b0, 32'(i));
      chk($sformatf("fill%0d count", i),  32'(b_cnt),    32'(i + 1));
      chk($sformatf("fill%0d af", i),     32'(b_af),     32'((i + 1) >= 14));
      chk($sformatf("fill%0d full_n", i), 32'(b_full_n), 32'((i + 1) != 16));
      chk($sformatf("fill%0d dout", i),   b_dout,        32'd0);
    end
    chk("fill max", 32'(b_max), 32'd16);

    // Big: drain, head presented before each read
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain%0d dout", i), b_dout, 32'(i));
      bcyc(1'b0, 1'b0, 1'b1, 32'd0);
      chk($sformatf("drain%0d count", i), 32'(b_cnt), 32'(15 - i));
    end
    chk("drain empty_n", 32'(b_empty_n), 32'd0);
    chk("drain ae",      32'(b_ae),      32'd1);
    chk("drain max",     32'(b_max),     32'd16);

    // Big: read+write while full -> write refused, overflow sticky
    for (int i = 0; i < 16; i++) bcyc(1'b0, 1'b1, 1'b0, 32'(100 + i));
    bcyc(1'b0, 1'b1, 1'b1, 32'hAA);
    chk("full rw count", 32'(b_cnt), 32'd15);
    chk("full rw ovf",   32'(b_ovf), 32'd1);
    chk("full rw unf",   32'(b_unf), 32'd0);
    bcyc(1'b0, 1'b1, 1'b0, 32'hBB);
    chk("after BB count", 32'(b_cnt), 32'd16);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("ovf drain%0d dout", i), b_dout, (i < 15) ? 32'(101 + i) : 32'hBB);
      bcyc(1'b0, 1'b0, 1'b1, 32'd0);
    end
    chk("ovf drain empty_n", 32'(b_empty_n), 32'd0);
    chk("ovf sticky", 32'(b_ovf), 32'd1);

    // Big: read+write while empty -> read refused, underflow sticky
    bcyc(1'b0, 1'b1, 1'b1, 32'h5);
    chk("empty rw count",   32'(b_cnt),     32'd1);
    chk("empty rw unf",     32'(b_unf),     32'd1);
    chk("empty rw empty_n", 32'(b_empty_n), 32'd1);
    chk("empty rw dout",    b_dout,         32'h5);
    bcyc(1'b0, 1'b0, 1'b1, 32'd0);
    chk("empty rw drained", 32'(b_cnt), 32'd0);

    // Big: count 8, 20 cycles of simultaneous read+write
    for (int i = 0; i < 8; i++) bcyc(1'b0, 1'b1, 1'b0, 32'(200 + i));
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("stream%0d dout", k), b_dout, (k < 8) ? 32'(200 + k) : 32'(300 + k - 8));
      bcyc(1'b0, 1'b1, 1'b1, 32'(300 + k));
      chk($sformatf("stream%0d count", k), 32'(b_cnt), 32'd8);
    end

    // Big: count 10 with both errors set, flush beats a concurrent write
    bcyc(1'b0, 1'b1, 1'b0, 32'd400);
    bcyc(1'b0, 1'b1, 1'b0, 32'd401);
    chk("pre-flush count", 32'(b_cnt), 32'd10);
    chk("pre-flush ovf",   32'(b_ovf), 32'd1);
    chk("pre-flush unf",   32'(b_unf), 32'd1);
    bcyc(1'b1, 1'b1, 1'b0, 32'hDEAD);
    chk_big_reset_state("flush");
    bcyc(1'b0, 1'b1, 1'b0, 32'h77);
    chk("post-flush count", 32'(b_cnt), 32'd1);
    chk("post-flush dout",  b_dout,     32'h77);
    chk("post-flush max",   32'(b_max), 32'd1);

    // Big: reset wins over flush/read/write
    b_reset = 1'b1;
    bcyc(1'b1, 1'b1, 1'b1, 32'h1);
    b_reset = 1'b0;
    chk_big_reset_state("big mid reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
